bf16_conv_arbiter: RTL and testbench
====================================

BF16_CONV_ARBITER -- requirements
Module: bf16_conv_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters (2..8).
REQ-002 Parameter: IDW, $clog2(NUM_REQ), requester ID width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester request; held until accepted.
REQ-006 req_data  in  16*NUM_REQ  packed signed Q2.14 operands; lane i = bits [16i+15:16i].
REQ-007 req_ready  out  NUM_REQ  one-hot accept pulse to the granted requester.
REQ-008 res_valid  out  1  BF16 result available; held until res_ready.
REQ-009 res_data  out  16  BF16 result: sign, 8-bit exponent, 7-bit mantissa.
REQ-010 res_id  out  IDW  index of the requester that owns res_data.
REQ-011 res_ready  in  1  downstream accept.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 conv_count  out  16  completed-result count; wraps 0xFFFF->0x0000.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-015 IDLE: if any req_valid, grant the first set bit at or after rr_ptr, searching upward with wrap; pulse req_ready[g] for that cycle; capture lane g and g; go to ISSUE.
REQ-016 ISSUE: pulse engine start for one cycle; go to WAIT.
REQ-017 WAIT: on engine done, latch the engine result; go to HOLD.
REQ-018 HOLD: assert res_valid with stable res_data/res_id; when res_ready is high, increment conv_count, set rr_ptr = (g+1) mod NUM_REQ, and go to IDLE.
REQ-019 Latency: accept in cycle T gives start at T+1, engine done at T+4 and res_valid at T+5, independent of operand value.
REQ-020 No bypass: res_ready and new requests in the same HOLD cycle give a next grant no earlier than the following IDLE cycle; peak throughput is 1 result per 6 cycles.
REQ-021 req_ready SHALL be high only in IDLE, at most one bit at a time, and never without the matching req_valid.
REQ-022 Requests arriving outside IDLE are not sampled and wait; a req_valid that drops before grant is ignored.
REQ-023 Conversion: value = q * 2^-14; result = 0x0000 for q = 0.
REQ-024 Conversion, nonzero q: sign = q[15]; a = |q| as 16-bit unsigned; L = position of leading 1 of a.
REQ-025 Conversion, nonzero q: exp = L + 113; mantissa = the 7 bits below the leading 1, truncated, zero-filled when L < 7.
REQ-026 Conversion edge: q = 0x8000 gives 0xC000 (-2.0); infinity/NaN are never produced.

Reset
REQ-027 rst SHALL force state IDLE, rr_ptr 0, req_ready 0, res_valid 0, res_data 0x0000, res_id 0, busy 0 and conv_count 0 on the next edge.
REQ-028 Reset in any state SHALL abort the in-flight conversion, discard its result and reset the engine; no res_valid follows.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the BF16 exponent bias (127) and the Q2.14 fraction-bit constant (14).
REQ-030 One sub-module, q14_bf16_engine, SHALL implement REQ-023..026 with start/done handshake, fixed 3-cycle start-to-done latency and the same sync reset.
REQ-031 Arbitration, capture registers, FSM and counter SHALL live in bf16_conv_arbiter.

Verification
REQ-032 Single request: lane 0 = 0x4000 (1.0), res_ready = 1 -> req_ready[0] at T, res_valid at T+5, res_data 0x3F80, res_id 0.
REQ-033 Encodings: 0x0000 -> 0x0000; 0xC000 -> 0xBF80; 0x8000 -> 0xC000; 0x0001 -> 0x3880; 0x6000 -> 0x3FC0.
REQ-034 Round-robin: all 4 req_valid held high -> grant order 0,1,2,3,0; conv_count increments once per result.
REQ-035 Backpressure: res_ready low for 10 cycles in HOLD -> res_valid/res_data stable and no req_ready pulses; release -> IDLE.
REQ-036 Mid-operation reset: assert rst in WAIT -> all outputs at reset values next cycle, no res_valid, next grant starts at requester 0.
REQ-037 Wrap: preload to 0xFFFF conversions, complete one more -> conv_count 0x0000.

Source files
------------

// File: rtl/bf16_conv_arbiter_pkg.sv
// Shared types and constants for the round-robin Q2.14 -> BF16 conversion arbiter.
// Also holds the leading-one helper used by the conversion engine.
package bf16_conv_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_e;

   localparam int BF16_BIAS   = 127;
   localparam int Q_FRAC_BITS = 14;
   localparam int EXP_OFFSET  = BF16_BIAS - Q_FRAC_BITS;

   // Highest set bit wins because the scan runs upward and overwrites.
   function automatic logic [3:0] leadingOne(input logic [15:0] a);
      logic [3:0] pos;
      pos = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (a[i]) pos = 4'(i);
      end
      return pos;
   endfunction

endpackage

// File: rtl/bf16_conv_arbiter_if.sv
// Request/result bundle between the requesters, the arbiter and the result consumer.
interface bf16_conv_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) ();

   logic [NUM_REQ-1:0]    req_valid;
   logic [16*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  res_valid;
   logic [15:0]           res_data;
   logic [IDW-1:0]        res_id;
   logic                  res_ready;

   modport master (
      output req_valid, req_data, res_ready,
      input  req_ready, res_valid, res_data, res_id
   );

   modport slave (
      input  req_valid, req_data, res_ready,
      output req_ready, res_valid, res_data, res_id
   );

endinterface

// File: rtl/bf16_conv_arbiter_engine.sv
// Three-stage Q2.14 to BF16 converter: operand capture, magnitude, pack.
// done_o rises exactly three cycles after start_i regardless of operand value.
module q14_bf16_engine
   import bf16_conv_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [15:0] operand_i,
   output logic        done_o,
   output logic [15:0] result_o
);

   logic [2:0]  stageVld_q;
   logic [15:0] op_q;
   logic [15:0] mag_q;
   logic        sign_q;
   logic [15:0] result_q;
   logic [3:0]  lead;
   logic [7:0]  expo;
   logic [6:0]  mant;

   // Shifting the leading one up to bit 15 leaves the mantissa in bits 14:8, zero-filled for small values.
   always_comb begin
      lead = leadingOne(mag_q);
      expo = 8'(32'(lead) + EXP_OFFSET);
      mant = 7'((mag_q << (4'd15 - lead)) >> 8);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stageVld_q <= '0;
         op_q       <= '0;
         mag_q      <= '0;
         sign_q     <= 1'b0;
         result_q   <= '0;
      end else begin
         stageVld_q <= {stageVld_q[1:0], start_i};
         if (start_i) op_q <= operand_i;
         if (stageVld_q[0]) begin
            sign_q <= op_q[15];
            mag_q  <= op_q[15] ? (~op_q + 16'd1) : op_q;
         end
         if (stageVld_q[1]) begin
            result_q <= (mag_q == 16'd0) ? 16'h0000 : {sign_q, expo, mant};
         end
      end
   end

   assign done_o   = stageVld_q[2];
   assign result_o = result_q;

endmodule

// File: rtl/bf16_conv_arbiter.sv
// Round-robin arbiter feeding a shared Q2.14 -> BF16 engine, one conversion in flight at a time.
module bf16_conv_arbiter
   import bf16_conv_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                clk,
   input  logic                rst,
   bf16_conv_arbiter_if.slave  bus,
   output logic                busy,
   output logic [15:0]         conv_count
);

   state_e             state_q, state_d;
   logic [IDW-1:0]     rrPtr_q;
   logic [IDW-1:0]     gntId_q;
   logic [IDW-1:0]     gntIdx;
   logic               anyValid;
   logic               accept;
   logic [NUM_REQ-1:0] reqReady;
   logic [15:0]        opnd_q;
   logic [15:0]        resData_q;
   logic [15:0]        convCount_q;
   logic               engStart;
   logic               engDone;
   logic [15:0]        engResult;

   // First valid requester at or after rrPtr_q, wrapping around.
   always_comb begin
      int idx;
      anyValid = 1'b0;
      gntIdx   = '0;
      idx      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rrPtr_q) + i) % NUM_REQ;
         if (!anyValid && bus.req_valid[idx]) begin
            anyValid = 1'b1;
            gntIdx   = IDW'(idx);
         end
      end
   end

   assign accept = (state_q == IDLE) && anyValid && !rst;

   always_comb begin
      state_d  = state_q;
      engStart = 1'b0;
      reqReady = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               reqReady[gntIdx] = 1'b1;
               state_d          = ISSUE;
            end
         end
         ISSUE: begin
            engStart = 1'b1;
            state_d  = WAIT;
         end
         WAIT: begin
            if (engDone) state_d = HOLD;
         end
         HOLD: begin
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rrPtr_q     <= '0;
         gntId_q     <= '0;
         opnd_q      <= '0;
         resData_q   <= '0;
         convCount_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            gntId_q <= gntIdx;
            opnd_q  <= bus.req_data[{gntIdx, 4'b0000} +: 16];
         end
         if (state_q == WAIT && engDone) resData_q <= engResult;
         if (state_q == HOLD && bus.res_ready) begin
            convCount_q <= convCount_q + 16'd1;
            rrPtr_q     <= (gntId_q == IDW'(NUM_REQ - 1)) ? '0 : gntId_q + IDW'(1);
         end
      end
   end

   q14_bf16_engine u_engine (
      .clk       (clk),
      .rst       (rst),
      .start_i   (engStart),
      .operand_i (opnd_q),
      .done_o    (engDone),
      .result_o  (engResult)
   );

   assign bus.req_ready = reqReady;
   assign bus.res_valid = (state_q == HOLD);
   assign bus.res_data  = resData_q;
   assign bus.res_id    = gntId_q;
   assign busy          = (state_q != IDLE);
   assign conv_count    = convCount_q;

endmodule

// File: tb/tb_bf16_conv_arbiter.sv
// Scoreboard bench for bf16_conv_arbiter: a cycle model predicts grants, result timing and values.
module tb_bf16_conv_arbiter;

   localparam int NREQ = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [15:0] convCount;

   always #5 clk = ~clk;

   bf16_conv_arbiter_if #(.NUM_REQ(NREQ), .IDW(2)) bus ();

   bf16_conv_arbiter #(.NUM_REQ(NREQ), .IDW(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .conv_count (convCount)
   );

   typedef struct {
      logic [1:0]  id;
      logic [15:0] data;
   } exp_t;

   exp_t        sb[$];
   int          totalCnt   = 0;
   int          badCnt     = 0;
   int          cycleNo    = 0;
   int          grantCycle = 0;
   int          mPtr       = 0;
   bit          resetSeen  = 1'b0;
   bit          justReset  = 1'b0;
   bit          mIdle      = 1'b1;
   bit          pending    = 1'b0;
   logic [15:0] mCount     = 16'h0;
   logic [3:0]  lastReady  = 4'h0;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act !== exp) begin
         badCnt++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cycleNo);
      end
   endtask

   // Reference conversion straight from the number format: normalise until bit 15 is set.
   function automatic logic [15:0] refConv(input logic [15:0] q);
      logic [15:0] m;
      int          e;
      if (q == 16'h0000) return 16'h0000;
      m = q[15] ? (~q + 16'd1) : q;
      e = 15;
      while (!m[15]) begin
         m = m << 1;
         e--;
      end
      return {q[15], 8'(e + 113), m[14:8]};
   endfunction

   // Runs at the falling edge: predicts this cycle's outputs, compares, then advances the model.
   task automatic monitorStep();
      logic [3:0] expReady;
      int         g;
      int         idx;
      bit         expHold;
      exp_t       e;
      lastReady = bus.req_ready;
      if (rst) begin
         resetSeen = 1'b1;
         justReset = 1'b1;
         sb.delete();
         mPtr    = 0;
         mIdle   = 1'b1;
         pending = 1'b0;
         mCount  = 16'h0;
         return;
      end
      if (!resetSeen) return;
      expReady = 4'h0;
      g        = 0;
      if (mIdle) begin
         for (int i = 0; i < NREQ; i++) begin
            idx = (mPtr + i) % NREQ;
            if (bus.req_valid[idx] && expReady == 4'h0) begin
               expReady[idx] = 1'b1;
               g             = idx;
            end
         end
      end
      expHold = pending && (cycleNo >= grantCycle + 5);
      checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
      checkOutput("res_valid", 32'(bus.res_valid), 32'(expHold));
      checkOutput("busy", 32'(busy), 32'(!mIdle));
      checkOutput("conv_count", 32'(convCount), 32'(mCount));
      if (justReset) begin
         checkOutput("rst_res_data", 32'(bus.res_data), 32'h0);
         checkOutput("rst_res_id", 32'(bus.res_id), 32'h0);
         justReset = 1'b0;
      end
      if (expHold && sb.size() > 0) begin
         checkOutput("res_data", 32'(bus.res_data), 32'(sb[0].data));
         checkOutput("res_id", 32'(bus.res_id), 32'(sb[0].id));
         if (bus.res_ready) begin
            e       = sb.pop_front();
            mCount  = mCount + 16'd1;
            mPtr    = (int'(e.id) + 1) % NREQ;
            pending = 1'b0;
            mIdle   = 1'b1;
         end
      end
      if (expReady != 4'h0) begin
         e.id   = 2'(g);
         e.data = refConv(bus.req_data[16*g +: 16]);
         sb.push_back(e);
         grantCycle = cycleNo;
         pending    = 1'b1;
         mIdle      = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitorStep();
      @(posedge clk);
      #1;
      cycleNo++;
   endtask

   task automatic applyStimulus(input int lane, input logic [15:0] val);
      bus.req_data[16*lane +: 16] = val;
      bus.req_valid[lane]         = 1'b1;
   endtask

   task automatic waitGrant(input int lane);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!lastReady[lane] && n < 40);
      if (!lastReady[lane]) checkOutput("grant_timeout", 32'd1, 32'd0);
      bus.req_valid[lane] = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((pending || sb.size() != 0) && n < 60) begin
         tick();
         n++;
      end
      if (pending || sb.size() != 0) checkOutput("drain_timeout", 32'd1, 32'd0);
      tick();
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] encVals [5];
      int          grants;
      int          n;
      encVals[0] = 16'h0000;
      encVals[1] = 16'hC000;
      encVals[2] = 16'h8000;
      encVals[3] = 16'h0001;
      encVals[4] = 16'h6000;

      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.res_ready = 1'b1;
      doReset();
      tick();

      $display("[TB] single request, lane 0 = 1.0");
      applyStimulus(0, 16'h4000);
      waitGrant(0);
      drain();

      $display("[TB] encoding table and random operands");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(i % NREQ, encVals[i]);
         waitGrant(i % NREQ);
         drain();
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus((i + 1) % NREQ, 16'($urandom_range(0, 65535)));
         waitGrant((i + 1) % NREQ);
         drain();
      end

      $display("[TB] round-robin with all requesters held");
      doReset();
      for (int i = 0; i < NREQ; i++) applyStimulus(i, 16'h1000 * 16'(i + 1) + 16'h0123);
      grants = 0;
      n      = 0;
      while (grants < 5 && n < 80) begin
         tick();
         n++;
         if (lastReady != 4'h0) grants++;
      end
      if (grants < 5) checkOutput("rr_timeout", 32'd1, 32'd0);
      bus.req_valid = '0;
      drain();

      $display("[TB] backpressure in HOLD");
      bus.res_ready = 1'b0;
      applyStimulus(1, 16'h1234);
      waitGrant(1);
      repeat (5) tick();
      applyStimulus(2, 16'hF00D);
      repeat (10) tick();
      bus.res_ready = 1'b1;
      waitGrant(2);
      drain();

      $display("[TB] reset during WAIT");
      applyStimulus(1, 16'h2222);
      waitGrant(1);
      tick();
      rst = 1'b1;
      applyStimulus(0, 16'h3000);
      applyStimulus(3, 16'hD000);
      tick();
      rst = 1'b0;
      waitGrant(0);
      waitGrant(3);
      drain();

      $display("[TB] conversion counter wrap");
      tick();
      dut.convCount_q = 16'hFFFF;
      mCount          = 16'hFFFF;
      applyStimulus(2, 16'h6000);
      waitGrant(2);
      drain();
      checkOutput("conv_count_wrap", 32'(convCount), 32'h0);

      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
